// File: rtl/game_pkg.sv
// Shared definitions for the Breakout game-flow logic: game states and the
// default game constants also used by the scoreboard and ball logic.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_LOST     = 3'd3,
        ST_GAMEOVER = 3'd4,
        ST_WIN      = 3'd5
    } game_state_t;

    localparam int GAME_LIVES       = 10;
    localparam int GAME_NBLOCKS     = 40;
    localparam int GAME_DEBOUNCE    = 16;
    localparam int GAME_SERVE_DELAY = 64;

endpackage

// File: rtl/btn_debounce.sv
// Start-button conditioning: 2-FF synchronizer, stability debouncer and a
// registered one-cycle pulse on each debounced rising edge.
module btn_debounce #(
    parameter int DEBOUNCE = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic btn_press
);
    localparam int CW = $clog2(DEBOUNCE + 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;

    // Synchronize, accept a new level after DEBOUNCE differing cycles, pulse on rise
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            stable    <= 1'b0;
            stable_d  <= 1'b0;
            cnt       <= '0;
            btn_press <= 1'b0;
        end else begin
            sync1     <= btn;
            sync2     <= sync1;
            stable_d  <= stable;
            btn_press <= stable & ~stable_d;
            if (sync2 != stable) begin
                if (cnt == CW'(DEBOUNCE - 1)) begin
                    stable <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/game_event_ctrl.sv
// Breakout game-flow controller: turns button presses and collision levels
// into start/hit_block/endgame pulses and serve/play/win/game-over levels.
module game_event_ctrl
    import game_pkg::*;
#(
    parameter int LIVES       = GAME_LIVES,
    parameter int NBLOCKS     = GAME_NBLOCKS,
    parameter int DEBOUNCE    = GAME_DEBOUNCE,
    parameter int SERVE_DELAY = GAME_SERVE_DELAY
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         btn_start,
    input  logic                         ball_bottom,
    input  logic                         block_collide,
    output logic                         hit_block,
    output logic                         endgame,
    output logic                         start,
    output logic                         serve,
    output logic                         play_en,
    output logic                         game_over,
    output logic                         win,
    output logic [$clog2(LIVES+1)-1:0]   lives_left,
    output logic [$clog2(NBLOCKS+1)-1:0] blocks_left
);
    localparam int LW = $clog2(LIVES + 1);
    localparam int BW = $clog2(NBLOCKS + 1);
    localparam int SW = $clog2(SERVE_DELAY + 1);

    game_state_t   state;
    logic [SW-1:0] serve_cnt;
    logic          btn_press;
    logic          prev_bottom;
    logic          prev_block;
    logic          bottom_rise;
    logic          block_rise;

    btn_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_btn (
        .clock     (clock),
        .reset     (reset),
        .btn       (btn_start),
        .btn_press (btn_press)
    );

    // Edges are taken against the previous cycle regardless of state, so a
    // level already high on entry to PLAY never counts as a new event.
    assign bottom_rise = ball_bottom & ~prev_bottom;
    assign block_rise  = block_collide & ~prev_block;

    // Game-flow FSM with registered pulses, levels and mirror counters
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            serve_cnt   <= '0;
            prev_bottom <= 1'b0;
            prev_block  <= 1'b0;
            hit_block   <= 1'b0;
            endgame     <= 1'b0;
            start       <= 1'b0;
            serve       <= 1'b0;
            play_en     <= 1'b0;
            game_over   <= 1'b0;
            win         <= 1'b0;
            lives_left  <= LW'(LIVES);
            blocks_left <= BW'(NBLOCKS);
        end else begin
            prev_bottom <= ball_bottom;
            prev_block  <= block_collide;
            hit_block   <= 1'b0;
            endgame     <= 1'b0;
            start       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (btn_press) begin
                        start     <= 1'b1;
                        state     <= ST_SERVE;
                        serve     <= 1'b1;
                        serve_cnt <= SW'(SERVE_DELAY - 1);
                    end
                end
                ST_SERVE: begin
                    if (btn_press || serve_cnt == '0) begin
                        state   <= ST_PLAY;
                        serve   <= 1'b0;
                        play_en <= 1'b1;
                    end else begin
                        serve_cnt <= serve_cnt - SW'(1);
                    end
                end
                ST_PLAY: begin
                    // A lost ball outranks a simultaneous block hit
                    if (bottom_rise) begin
                        endgame    <= 1'b1;
                        play_en    <= 1'b0;
                        lives_left <= (lives_left != '0) ? lives_left - LW'(1) : lives_left;
                        if (lives_left <= LW'(1)) begin
                            state     <= ST_GAMEOVER;
                            game_over <= 1'b1;
                        end else begin
                            state <= ST_LOST;
                        end
                    end else if (block_rise) begin
                        hit_block   <= 1'b1;
                        blocks_left <= (blocks_left != '0) ? blocks_left - BW'(1) : blocks_left;
                        if (blocks_left <= BW'(1)) begin
                            state   <= ST_WIN;
                            win     <= 1'b1;
                            play_en <= 1'b0;
                        end
                    end
                end
                ST_LOST: begin
                    if (!ball_bottom) begin
                        state     <= ST_SERVE;
                        serve     <= 1'b1;
                        serve_cnt <= SW'(SERVE_DELAY - 1);
                    end
                end
                ST_GAMEOVER: begin
                    game_over  <= 1'b1;
                    lives_left <= '0;
                end
                ST_WIN: begin
                    if (btn_press) begin
                        start       <= 1'b1;
                        win         <= 1'b0;
                        blocks_left <= BW'(NBLOCKS);
                        state       <= ST_SERVE;
                        serve       <= 1'b1;
                        serve_cnt   <= SW'(SERVE_DELAY - 1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    serve     <= 1'b0;
                    play_en   <= 1'b0;
                    game_over <= 1'b0;
                    win       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_event_ctrl.sv
// Directed bench for game_event_ctrl: a behavioural game model checked every
// cycle, plus literal expectations at each scenario checkpoint.
module tb_game_event_ctrl;
    localparam int LIVES = 10;
    localparam int NB    = 40;
    localparam int DB    = 16;
    localparam int SD    = 64;

    localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_LOST = 3, M_OVER = 4, M_WIN = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       btn_start = 1'b0;
    logic       ball_bottom = 1'b0;
    logic       block_collide = 1'b0;
    logic       hit_block, endgame, start, serve, play_en, game_over, win;
    logic [3:0] lives_left;
    logic [5:0] blocks_left;

    int tests = 0;
    int fails = 0;

    game_event_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .btn_start     (btn_start),
        .ball_bottom   (ball_bottom),
        .block_collide (block_collide),
        .hit_block     (hit_block),
        .endgame       (endgame),
        .start         (start),
        .serve         (serve),
        .play_en       (play_en),
        .game_over     (game_over),
        .win           (win),
        .lives_left    (lives_left),
        .blocks_left   (blocks_left)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_valid = 0;
    int cyc = 0;
    int run_val, run_len, deb;
    int pq[$];
    int m_state, m_lives, m_blocks, m_serve_cycles, m_prev_b, m_prev_c;
    int e_hit, e_end, e_start;

    initial forever begin
        int press, rb, rc;
        @(posedge clock);
        cyc++;
        if (reset) begin
            m_valid = 1;
            run_val = 0; run_len = 0; deb = 0;
            pq.delete();
            m_state = M_IDLE; m_lives = LIVES; m_blocks = NB;
            m_serve_cycles = 0; m_prev_b = 0; m_prev_c = 0;
            e_hit = 0; e_end = 0; e_start = 0;
        end else begin
            // a press reaches the FSM 4 edges after the raw level has been stable DB samples
            press = 0;
            if (pq.size() > 0 && pq[0] == cyc) begin
                press = 1;
                pq.delete(0);
            end
            if (int'(btn_start) == run_val) run_len++;
            else begin run_val = int'(btn_start); run_len = 1; end
            if (run_len == DB && run_val != deb) begin
                deb = run_val;
                if (deb == 1) pq.push_back(cyc + 4);
            end

            rb = (ball_bottom && !m_prev_b) ? 1 : 0;
            rc = (block_collide && !m_prev_c) ? 1 : 0;
            m_prev_b = int'(ball_bottom);
            m_prev_c = int'(block_collide);
            e_hit = 0; e_end = 0; e_start = 0;
            case (m_state)
                M_IDLE: if (press) begin e_start = 1; m_state = M_SERVE; m_serve_cycles = 0; end
                M_SERVE: begin
                    m_serve_cycles++;
                    if (press || m_serve_cycles == SD) m_state = M_PLAY;
                end
                M_PLAY: begin
                    if (rb) begin
                        e_end = 1;
                        if (m_lives > 0) m_lives--;
                        m_state = (m_lives == 0) ? M_OVER : M_LOST;
                    end else if (rc) begin
                        e_hit = 1;
                        if (m_blocks > 0) m_blocks--;
                        if (m_blocks == 0) m_state = M_WIN;
                    end
                end
                M_LOST: if (!ball_bottom) begin m_state = M_SERVE; m_serve_cycles = 0; end
                M_WIN: if (press) begin
                    e_start = 1; m_blocks = NB; m_state = M_SERVE; m_serve_cycles = 0;
                end
                default: ;
            endcase
        end
    end

    // ---------------- per-cycle compare and event tally ----------------
    int ncyc = 0;
    int n_start = 0, n_hit = 0, n_end = 0;
    int start_seen = -1, play_rise_seen = -1;
    int last_play = 0;

    initial forever begin
        @(negedge clock);
        ncyc++;
        if (m_valid != 0) begin
            check("hit_block",   int'(hit_block),   e_hit);
            check("endgame",     int'(endgame),     e_end);
            check("start",       int'(start),       e_start);
            check("serve",       int'(serve),       (m_state == M_SERVE) ? 1 : 0);
            check("play_en",     int'(play_en),     (m_state == M_PLAY) ? 1 : 0);
            check("game_over",   int'(game_over),   (m_state == M_OVER) ? 1 : 0);
            check("win",         int'(win),         (m_state == M_WIN) ? 1 : 0);
            check("lives_left",  int'(lives_left),  m_lives);
            check("blocks_left", int'(blocks_left), m_blocks);
        end
        if (start) begin n_start++; start_seen = ncyc; end
        if (hit_block) n_hit++;
        if (endgame) n_end++;
        if (play_en && last_play == 0) play_rise_seen = ncyc;
        last_play = int'(play_en);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic press_btn();
        btn_start = 1'b1;
        repeat (30) tick();
        btn_start = 1'b0;
        repeat (25) tick();
    endtask

    task automatic wait_play();
        for (int i = 0; i < 300; i++) begin
            if (play_en) break;
            tick();
        end
        check("wait_play", int'(play_en), 1);
    endtask

    task automatic lose_ball();
        wait_play();
        ball_bottom = 1'b1;
        tick();
        ball_bottom = 1'b0;
        tick();
    endtask

    initial begin
        int n0, s0, h0, e0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_lives", int'(lives_left), 10);
        check("rst_blocks", int'(blocks_left), 40);
        check("rst_serve", int'(serve), 0);
        check("rst_play", int'(play_en), 0);

        // glitch shorter than the debounce window
        btn_start = 1'b1;
        repeat (10) tick();
        btn_start = 1'b0;
        repeat (30) tick();
        check("glitch_start", n_start, 0);
        check("glitch_idle", int'(serve), 0);

        // clean press: start latency and automatic launch
        n0 = ncyc;
        s0 = n_start;
        btn_start = 1'b1;
        repeat (40) tick();
        btn_start = 1'b0;
        check("start_once", n_start - s0, 1);
        check("start_latency", start_seen - n0, 20);
        check("serve_after_start", int'(serve), 1);
        wait_play();
        check("serve_len", play_rise_seen - start_seen, 64);

        // held collision counts once, re-rise counts again
        h0 = n_hit;
        block_collide = 1'b1;
        repeat (20) tick();
        block_collide = 1'b0;
        repeat (3) tick();
        block_collide = 1'b1;
        repeat (2) tick();
        block_collide = 1'b0;
        repeat (2) tick();
        check("hits_2", n_hit - h0, 2);
        check("blocks_38", int'(blocks_left), 38);

        // simultaneous rise: loss wins
        h0 = n_hit;
        e0 = n_end;
        ball_bottom = 1'b1;
        block_collide = 1'b1;
        repeat (3) tick();
        check("sim_end", n_end - e0, 1);
        check("sim_hit", n_hit - h0, 0);
        check("sim_lives", int'(lives_left), 9);
        check("sim_blocks", int'(blocks_left), 38);
        check("lost_noserve", int'(serve), 0);
        ball_bottom = 1'b0;
        block_collide = 1'b0;
        repeat (2) tick();
        check("lost_to_serve", int'(serve), 1);

        // remaining nine losses end the game
        for (int i = 0; i < 9; i++) lose_ball();
        repeat (2) tick();
        check("over_ends", n_end - e0, 10);
        check("over_level", int'(game_over), 1);
        check("over_lives", int'(lives_left), 0);
        s0 = n_start;
        press_btn();
        check("over_nostart", n_start - s0, 0);
        check("over_stays", int'(game_over), 1);

        // new game, lose one, clear all blocks, next level
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        s0 = n_start;
        press_btn();
        check("ng_start", n_start - s0, 1);
        lose_ball();
        check("ng_lives", int'(lives_left), 9);
        wait_play();
        h0 = n_hit;
        for (int i = 0; i < 40; i++) begin
            block_collide = 1'b1;
            tick();
            block_collide = 1'b0;
            tick();
        end
        tick();
        check("win_hits", n_hit - h0, 40);
        check("win_level", int'(win), 1);
        check("win_blocks", int'(blocks_left), 0);
        s0 = n_start;
        press_btn();
        check("lvl_start", n_start - s0, 1);
        check("lvl_blocks", int'(blocks_left), 40);
        check("lvl_lives", int'(lives_left), 9);
        check("lvl_serve", int'(serve), 1);

        // reset mid-serve
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_serve", int'(serve), 0);
        check("mid_rst_lives", int'(lives_left), 10);
        check("mid_rst_blocks", int'(blocks_left), 40);
        check("mid_rst_win", int'(win), 0);
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/game_event_ctrl.md
Name: game_event_ctrl

Overview:
- Game-flow controller for Breakout; produces the score/lives event stream consumed by the scoreboard.
- Events: start on new game, hit_block per block struck, endgame per ball lost.
- Takes a raw start button and the level-type collision flags from the ball/pixel logic.
- Also drives serve/play enables to the ball and paddle logic, and keeps mirror counters of lives and remaining blocks to decide game-over and win.

Parameters:
LIVES, 10, lives per game; must match the scoreboard's initial lives.
NBLOCKS, 40, breakable blocks per level.
DEBOUNCE, 16, consecutive stable cycles required to accept a button level change.
SERVE_DELAY, 64, cycles the ball is held on the paddle before automatic launch.

Ports:
clock  in  1  system clock.
reset  in  1  synchronous, active-high reset.
btn_start  in  1  raw push button, asynchronous, active-high.
ball_bottom  in  1  level: the ball is touching the bottom edge; synchronous to clock.
block_collide  in  1  level: the ball overlaps a live block; may stay high many cycles; synchronous.
hit_block  out  1  one-cycle pulse per block struck.
endgame  out  1  one-cycle pulse per ball lost.
start  out  1  one-cycle pulse: new game/level, score clears.
serve  out  1  level: ball parked on the paddle.
play_en  out  1  level: ball in motion.
game_over  out  1  level: lives exhausted.
win  out  1  level: all blocks cleared.
lives_left  out  $clog2(LIVES+1)  remaining lives.
blocks_left  out  $clog2(NBLOCKS+1)  remaining blocks.

Behaviour:

Reset values:
- All pulses, serve, play_en, game_over and win are 0.
- lives_left=LIVES, blocks_left=NBLOCKS, state IDLE.
- Synchronizer, debounce counter and edge registers are cleared.
- A reset mid-game forces this in one cycle; an in-flight pulse is dropped.

Button path:
- 2-FF synchronizer feeds the debouncer; the debounced level changes after DEBOUNCE consecutive cycles of a differing synchronized value.
- btn_press is the debounced rising edge.
- start asserts exactly DEBOUNCE+3 cycles after the first clock edge that samples btn_start=1 (stable).
- Glitches shorter than DEBOUNCE cycles produce nothing.

Collision edges:
- prev registers track ball_bottom and block_collide every cycle in every state.
- Events fire only on 0->1 transitions seen while in PLAY.
- A level already high when PLAY is entered produces no event.
- Output pulses are registered: one cycle after the sampled edge.

All pulse outputs are exactly one cycle wide. Back-to-back events are legal; pulses may occur on consecutive cycles.

FSM states:
- IDLE: all levels 0. On btn_press: start pulse, go SERVE.
- SERVE: serve=1, counter loads SERVE_DELAY on entry. Go PLAY when the counter reaches 0 or on btn_press, whichever is first.
- PLAY: play_en=1.
  - On block_collide rise: hit_block pulse, blocks_left-1. If blocks_left was 1, go WIN.
  - On ball_bottom rise: endgame pulse, lives_left-1. If lives_left was 1, go GAMEOVER; else go LOST.
  - Simultaneous rises: endgame wins and the hit is discarded (no pulse, no decrement), matching scoreboard priority.
- LOST: all levels 0. Wait for ball_bottom=0, then go SERVE.
- GAMEOVER: game_over=1, lives_left=0. btn_press is ignored; only reset exits.
- WIN: win=1. On btn_press: start pulse, blocks_left reloads NBLOCKS, lives_left kept, go SERVE.

Width/arithmetic:
- The counters never wrap.
- A decrement at 0 is impossible by construction; it must be guarded with saturation anyway.

Decomposition:
- Shared package game_pkg holds:
  - state enum (IDLE, SERVE, PLAY, LOST, GAMEOVER, WIN);
  - defaults for LIVES, NBLOCKS and DEBOUNCE, shared with the scoreboard and ball logic.
- One sub-module, btn_debounce: synchronizer, debounce counter and rising-edge pulse; parameter DEBOUNCE; output btn_press.

Test Plan:
1. Reset, btn_start high for 40 cycles -> start single pulse at cycle DEBOUNCE+3; serve=1. With no press, play_en=1 after 64 cycles.
2. Button glitch of 10 cycles high in IDLE -> no start pulse; state stays IDLE.
3. In PLAY, block_collide held high for 20 cycles, then low, then high again -> exactly 2 hit_block pulses; blocks_left 40->38.
4. In PLAY, ball_bottom and block_collide rise in the same cycle -> endgame pulse only; lives_left 10->9; blocks_left unchanged; LOST, then SERVE after ball_bottom falls.
5. Ten ball losses -> ten endgame pulses, game_over=1, lives_left=0. A subsequent btn_press produces no start.
6. Strike all 40 blocks -> win=1. btn_press -> start pulse, blocks_left=40, lives_left unchanged. Reset asserted mid-SERVE -> IDLE with all reset values next cycle.
